// File: rtl/fp32_seq_mult.sv
// Multi-cycle IEEE-754 single-precision multiplier: shift-add mantissa, fixed 26-edge latency, FTZ.
// Define FMUL_FLAGS_EN to add flags[3:0] = {invalid, overflow, underflow, inexact}.
module fp32_seq_mult #(
  parameter logic [31:0] QNAN_VALUE   = 32'h7FC0_0000,
  parameter bit          CLR_ON_START = 1'b0
) (
  input  logic        clk,
  input  logic        nRESET,
  input  logic        start,
  input  logic [31:0] mult_dina,
  input  logic [31:0] mult_dinb,
  output logic        busy,
  output logic        done,
  output logic [31:0] mult_dout
`ifdef FMUL_FLAGS_EN
  ,output logic [3:0] flags
`endif
);

  typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;
  typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

  state_t            state_reg, state_next;
  cls_t              cls_reg, cls_next;
  logic [4:0]        cnt_reg;
  logic [23:0]       mcand_reg;
  logic [47:0]       prod_reg;
  logic signed [9:0] exp_reg;
  logic              sign_reg;
  logic [22:0]       frac_reg;
  logic              guard_reg, sticky_reg;
  logic [31:0]       dout_reg;

  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [24:0]       acc_sum;
  logic              round_up, ovf, unf;
  logic [23:0]       frac_sum;
  logic signed [9:0] exp_rnd;
  logic [31:0]       pack;

  // Operand classification; subnormals count as zero.
  always_comb begin
    a_zero = (mult_dina[30:23] == 8'h00);
    b_zero = (mult_dinb[30:23] == 8'h00);
    a_inf  = (mult_dina[30:23] == 8'hFF) && (mult_dina[22:0] == 23'd0);
    b_inf  = (mult_dinb[30:23] == 8'hFF) && (mult_dinb[22:0] == 23'd0);
    a_nan  = (mult_dina[30:23] == 8'hFF) && (mult_dina[22:0] != 23'd0);
    b_nan  = (mult_dinb[30:23] == 8'hFF) && (mult_dinb[22:0] != 23'd0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
      cls_next = CLS_NAN;
    else if (a_inf || b_inf)
      cls_next = CLS_INF;
    else if (a_zero || b_zero)
      cls_next = CLS_ZERO;
    else
      cls_next = CLS_NUM;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = MUL;
      MUL:     if (cnt_reg == 5'd23) state_next = NORM;
      NORM:    state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == DONE);
  end

  // Upper half of the product accumulates the multiplicand; multiplier bits drain from the bottom.
  assign acc_sum = {1'b0, prod_reg[47:24]} + (prod_reg[0] ? {1'b0, mcand_reg} : 25'd0);

  always_comb begin
    round_up = guard_reg & (sticky_reg | frac_reg[0]);
    frac_sum = {1'b0, frac_reg} + {23'd0, round_up};
    exp_rnd  = exp_reg + $signed({9'd0, frac_sum[23]});
    ovf      = (cls_reg == CLS_NUM) && (exp_rnd >= 10'sd255);
    unf      = (cls_reg == CLS_NUM) && (exp_rnd <= 10'sd0);
    case (cls_reg)
      CLS_NAN:  pack = QNAN_VALUE;
      CLS_INF:  pack = {sign_reg, 8'hFF, 23'd0};
      CLS_ZERO: pack = {sign_reg, 31'd0};
      default: begin
        if (ovf)
          pack = {sign_reg, 8'hFF, 23'd0};
        else if (unf)
          pack = {sign_reg, 31'd0};
        else
          pack = {sign_reg, exp_rnd[7:0], frac_sum[22:0]};
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      cls_reg    <= CLS_NUM;
      cnt_reg    <= '0;
      mcand_reg  <= '0;
      prod_reg   <= '0;
      exp_reg    <= '0;
      sign_reg   <= 1'b0;
      frac_reg   <= '0;
      guard_reg  <= 1'b0;
      sticky_reg <= 1'b0;
      dout_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          cls_reg   <= cls_next;
          cnt_reg   <= '0;
          mcand_reg <= {1'b1, mult_dina[22:0]};
          prod_reg  <= {24'd0, 1'b1, mult_dinb[22:0]};
          exp_reg   <= $signed({2'b00, mult_dina[30:23]}) + $signed({2'b00, mult_dinb[30:23]}) - 10'sd127;
          sign_reg  <= mult_dina[31] ^ mult_dinb[31];
          if (CLR_ON_START)
            dout_reg <= '0;
        end
        MUL: begin
          prod_reg <= {acc_sum, prod_reg[23:1]};
          cnt_reg  <= cnt_reg + 5'd1;
        end
        NORM: begin
          if (prod_reg[47]) begin
            frac_reg   <= prod_reg[46:24];
            guard_reg  <= prod_reg[23];
            sticky_reg <= |prod_reg[22:0];
            exp_reg    <= exp_reg + 10'sd1;
          end else begin
            frac_reg   <= prod_reg[45:23];
            guard_reg  <= prod_reg[22];
            sticky_reg <= |prod_reg[21:0];
          end
        end
        ROUND:   dout_reg <= pack;
        default: ;
      endcase
    end
  end

  assign mult_dout = dout_reg;

`ifdef FMUL_FLAGS_EN
  logic [3:0] flags_reg;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET)
      flags_reg <= '0;
    else if (state_reg == IDLE && start)
      flags_reg <= '0;
    else if (state_reg == ROUND)
      flags_reg <= {cls_reg == CLS_NAN, ovf, unf,
                    (cls_reg == CLS_NUM) && (guard_reg | sticky_reg | ovf | unf)};
  end

  assign flags = flags_reg;
`endif

endmodule

// File: tb/tb_fp32_seq_mult.sv
// Self-checking bench for fp32_seq_mult: arithmetic reference model, per-cycle compare, directed vectors.
module tb_fp32_seq_mult;

  localparam bit CLR = 1'b0;

  logic        clk = 1'b0;
  logic        nRESET = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dina = '0;
  logic [31:0] dinb = '0;
  logic        busy, done;
  logic [31:0] dout;
`ifdef FMUL_FLAGS_EN
  logic [3:0]  flags;
`endif

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #10 clk = ~clk;

  fp32_seq_mult #(.QNAN_VALUE(32'h7FC0_0000), .CLR_ON_START(CLR)) dut (
    .clk(clk),
    .nRESET(nRESET),
    .start(start),
    .mult_dina(dina),
    .mult_dinb(dinb),
    .busy(busy),
    .done(done),
    .mult_dout(dout)
`ifdef FMUL_FLAGS_EN
    ,.flags(flags)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Exact integer product of the significands, then round-to-nearest-even on the remainder.
  function automatic logic [35:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, up, inexact;
    longint unsigned prod, m, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return {4'b1000, 32'h7FC0_0000};
    if (a_inf || b_inf) return {4'b0000, s, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {4'b0000, s, 31'd0};
    prod = (64'h80_0000 | 64'(a[22:0])) * (64'h80_0000 | 64'(b[22:0]));
    e = ea + eb - 127;
    if (prod >= 64'h8000_0000_0000) begin sh = 24; e++; end
    else sh = 23;
    m    = prod >> sh;
    rem  = prod - (m << sh);
    half = 64'd1 << (sh - 1);
    up   = (rem > half) || ((rem == half) && m[0]);
    inexact = (rem != 0);
    m = m + (up ? 64'd1 : 64'd0);
    if (m == 64'h100_0000) begin m = m >> 1; e++; end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
    if (e <= 0) return {4'b0011, s, 31'd0};
    return {3'b000, inexact, s, e[7:0], m[22:0]};
  endfunction

  // Timing reference: phase counts edges since the accepting edge; 27 is the done cycle.
  int          phase = 0;
  logic [31:0] m_dout = '0;
  logic [3:0]  m_flags = '0;
  logic [35:0] pend = '0;

  always @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      phase   <= 0;
      m_dout  <= '0;
      m_flags <= '0;
    end else if (phase == 0) begin
      if (start) begin
        phase   <= 1;
        pend    <= ref_mult(dina, dinb);
        m_flags <= '0;
        if (CLR) m_dout <= '0;
      end
    end else if (phase == 26) begin
      phase   <= 27;
      m_dout  <= pend[31:0];
      m_flags <= pend[35:32];
    end else if (phase == 27) begin
      phase <= 0;
    end else begin
      phase <= phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", busy, phase != 0);
      check("cyc_done", done, phase == 27);
      check("cyc_dout", dout, m_dout);
`ifdef FMUL_FLAGS_EN
      check("cyc_flags", flags, m_flags);
`endif
    end
  end

  task automatic run_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_d,
                         input logic [3:0] exp_f, input string name);
    int edges;
    logic [35:0] r;
    r = ref_mult(a, b);
    check({name, "/model"}, r[31:0], exp_d);
    check({name, "/model_flags"}, r[35:32], exp_f);
    @(negedge clk); start = 1'b1; dina = a; dinb = b;
    @(posedge clk); #1 check({name, "/busy_E0"}, busy, 1);
    @(negedge clk); start = 1'b0;
    edges = 0;
    do begin
      @(posedge clk); edges++;
      @(negedge clk);
    end while (!done && edges < 40);
    check({name, "/latency"}, edges, 26);
    check({name, "/dout"}, dout, exp_d);
`ifdef FMUL_FLAGS_EN
    check({name, "/flags"}, flags, exp_f);
`endif
    @(negedge clk);
    check({name, "/busy_after"}, busy, 0);
    check({name, "/done_after"}, done, 0);
    $display("txn %s a=%h b=%h dout=%h latency=%0d", name, a, b, dout, edges);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    #3 nRESET = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dout", dout, 0);
`ifdef FMUL_FLAGS_EN
    check("rst_flags", flags, 0);
`endif
    #2 nRESET = 1'b1;
    chk_en = 1'b1;

    run_vec(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000, "two_x_three");
    run_vec(32'h4084_CCCD, 32'h4084_CCCD, 32'h4189_C7AE, 4'b0001, "4p15_sq");
    run_vec(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, "inf_x_zero");
    run_vec(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, "ninf_x_two");
    run_vec(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0101, "overflow");
    run_vec(32'h0080_0000, 32'hBF00_0000, 32'h8000_0000, 4'b0011, "underflow");
    run_vec(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, "nan_in");
    run_vec(32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 4'b0000, "subnormal_ftz");
    run_vec(32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 4'b0001, "tie_round_up");
    run_vec(32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004, 4'b0001, "tie_keep_even");
    run_vec(32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 4'b0001, "max_mant");
    run_vec(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 4'b0000, "min_normal");
    run_vec(32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000, 4'b0000, "neg_sign");
    run_vec(32'h8000_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b1000, "nzero_x_ninf");

    // Second start at E10 must be ignored.
    @(negedge clk); start = 1'b1; dina = 32'h4000_0000; dinb = 32'h4040_0000;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); start = 1'b1; dina = 32'h3F80_0000; dinb = 32'h3F80_0000;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (done) n_done++; end
    check("restart_done_count", n_done, 1);
    check("restart_dout", dout, 32'h40C0_0000);
    $display("txn restart_ignored dout=%h dones=%0d", dout, n_done);

    // Reset asserted after E12 aborts the operation.
    @(negedge clk); start = 1'b1; dina = 32'h4084_CCCD; dinb = 32'h4084_CCCD;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (12) @(posedge clk);
    #2 nRESET = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dout", dout, 0);
    repeat (2) @(negedge clk);
    #2 nRESET = 1'b1;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); if (done) n_done++; end
    check("abort_no_stale_done", n_done, 0);
    $display("txn reset_abort dout=%h stale_dones=%0d", dout, n_done);
    run_vec(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000, "after_reset");

    // Start held high: back-to-back operations.
    @(negedge clk); start = 1'b1; dina = 32'h3FC0_0000; dinb = 32'h4000_0000;
    n_done = 0;
    for (int i = 0; i < 80 && n_done < 2; i++) begin @(negedge clk); if (done) n_done++; end
    start = 1'b0;
    check("held_two_ops", n_done, 2);
    check("held_dout", dout, 32'h4040_0000);
    $display("txn held_start dout=%h dones=%0d", dout, n_done);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp32_seq_mult.md
Name: fp32_seq_mult

Overview:
- Multi-cycle IEEE-754 single-precision multiplier on the FPGA board.
- Consumes the two operands driven by the host interface (mult_dina/mult_dinb) and returns mult_dout for host readback and 7-segment display.
- Uses a start/done handshake and a shift-add mantissa datapath: one mantissa bit per cycle, small area, fixed latency.

Parameters:
- QNAN_VALUE, 32'h7FC0_0000, canonical quiet NaN returned for every invalid or NaN case.
- CLR_ON_START, 0, 1 = mult_dout cleared to 0 at accepted start; 0 = previous result held until the new done.

Ports:
- clk  in  1  system clock (50 MHz).
- nRESET  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- mult_dina  in  32  operand A (FP32), latched at accepted start.
- mult_dinb  in  32  operand B (FP32), latched at accepted start.
- busy  out  1  high from the edge accepting start until the edge leaving DONE.
- done  out  1  single-cycle completion pulse.
- mult_dout  out  32  product (FP32), held between operations.

Behaviour:
- Reset (async, nRESET low): state=IDLE, busy=0, done=0, mult_dout=0, internal regs 0. Reset mid-operation aborts with no done pulse.
- States: IDLE, MUL, NORM, ROUND, DONE.
- IDLE: start=1 at edge E0 latches both operands, sets busy=1, goes to MUL with cnt=0. If CLR_ON_START=1, mult_dout<=0 at E0.
- MUL: 24 cycles (edges E1..E24). Each cycle adds the multiplicand (24-bit, hidden bit included) into a 48-bit accumulator when the current multiplier bit is 1, then shifts. At cnt=23, go to NORM.
- NORM (E25):
  - If p[47]=1: shift right 1, exp+1.
  - Form 23-bit fraction plus guard bit and sticky (OR of the remaining low bits).
- ROUND (E26):
  - Round-to-nearest-even; a carry out of the mantissa increments exp.
  - Pack into mult_dout; go to DONE.
- DONE: done=1 for exactly the cycle after E26. Next edge returns to IDLE with busy=0. Latency is fixed at 26 edges for all operand classes.
- start while busy=1 is ignored; operands are not re-sampled.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE.
- Exponent: 10-bit signed, e = ea + eb - 127.
  - e>=255 after rounding: signed infinity (overflow).
  - e<=0: signed zero (flush-to-zero, underflow).
- Sign is always sa XOR sb, except NaN results.
- Classification (decided at E0, registered, overrides pack at ROUND):
  - Subnormal inputs are treated as zero (FTZ).
  - Any NaN input, or Inf*0: QNAN_VALUE.
  - Inf*finite-nonzero: signed Inf.
  - 0*finite: signed zero.
- mult_dout changes only at the ROUND->DONE edge (or at start if CLR_ON_START=1).

Optional Feature:
- Macro: FMUL_FLAGS_EN.
- Defined: adds output port flags[3:0] = {invalid, overflow, underflow, inexact}.
  - Written at the same edge as mult_dout and held until the next result.
  - Reset value 0; cleared at accepted start.
  - inexact = guard|sticky nonzero, or overflow/underflow occurred.
- Undefined: port and flag logic are absent; all other behaviour is identical.

Test Plan:
- A=32'h4000_0000, B=32'h4040_0000, start pulse -> done exactly 26 edges later, mult_dout=32'h40C0_0000, busy high for 27 cycles; flags=0 (if enabled).
- A=B=32'h4084_CCCD (4.15) -> mult_dout=32'h4189_C7AE; inexact=1 (if enabled).
- A=32'h7F80_0000, B=32'h0000_0000 -> mult_dout=32'h7FC0_0000, invalid=1; same latency. A=32'hFF80_0000, B=32'h4000_0000 -> 32'hFF80_0000.
- A=B=32'h7F00_0000 -> 32'h7F80_0000, overflow=1. A=32'h0080_0000, B=32'hBF00_0000 -> 32'h8000_0000, underflow=1.
- Start pulsed again at E10 with new operands -> ignored; the result is from the first operands, and only one done pulse occurs.
- nRESET asserted at E12 -> busy=0, done=0, mult_dout=0 immediately. After release, a fresh start runs normally with no stale done.
